// File: rtl/bit_serializer.sv
// Parallel-to-serial stage: WIDTH-bit words in over valid/ready, one bit per clock out on x.
// Latency: bit i of a word accepted at edge k appears after edge k+i; back-to-back words have no gap.
// Backpressure: in_ready only in IDLE or while the last bit of a word is on x (combinational).
module bit_serializer #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             x,
    output logic             x_valid,
    output logic             busy
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] sreg_q, sreg_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             x_q, x_d;
    logic             xv_q, xv_d;
    logic             accept;

    assign in_ready = !rst && ((state_q == IDLE) || (cnt_q == '0));
    assign accept   = in_valid && in_ready;

    assign x       = x_q;
    assign x_valid = xv_q;
    assign busy    = (state_q == SHIFT);

    always_comb begin
        state_d = state_q;
        sreg_d  = sreg_q;
        cnt_d   = cnt_q;
        x_d     = x_q;
        xv_d    = xv_q;
        if (accept) begin
            // First bit goes straight to x; the rest sit in sreg aligned at the output end.
            x_d     = MSB_FIRST ? in_data[WIDTH-1] : in_data[0];
            sreg_d  = MSB_FIRST ? (in_data << 1) : (in_data >> 1);
            cnt_d   = CW'(WIDTH - 1);
            xv_d    = 1'b1;
            state_d = SHIFT;
        end else if ((state_q == SHIFT) && (cnt_q != '0)) begin
            x_d    = MSB_FIRST ? sreg_q[WIDTH-1] : sreg_q[0];
            sreg_d = MSB_FIRST ? (sreg_q << 1) : (sreg_q >> 1);
            cnt_d  = cnt_q - CW'(1);
        end else begin
            x_d     = 1'b0;
            xv_d    = 1'b0;
            sreg_d  = '0;
            cnt_d   = '0;
            state_d = IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            sreg_q  <= '0;
            cnt_q   <= '0;
            x_q     <= 1'b0;
            xv_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            sreg_q  <= sreg_d;
            cnt_q   <= cnt_d;
            x_q     <= x_d;
            xv_q    <= xv_d;
        end
    end

endmodule

// File: tb/tb_bit_serializer.sv
// Bench for bit_serializer: an 8-bit MSB-first and a 4-bit LSB-first instance against a bit-queue model.
module tb_bit_serializer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic [7:0] d8;
    logic       v8;
    logic       r8, x8, xv8, b8;
    logic [3:0] d4;
    logic       v4;
    logic       r4, x4, xv4, b4;

    bit_serializer #(.WIDTH(8), .MSB_FIRST(1'b1)) u8 (
        .clk(clk), .rst(rst), .in_data(d8), .in_valid(v8),
        .in_ready(r8), .x(x8), .x_valid(xv8), .busy(b8)
    );

    bit_serializer #(.WIDTH(4), .MSB_FIRST(1'b0)) u4 (
        .clk(clk), .rst(rst), .in_data(d4), .in_valid(v4),
        .in_ready(r4), .x(x4), .x_valid(xv4), .busy(b4)
    );

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    bit q8[$];
    bit q4[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic act, input logic exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %b expected %b at cycle %0d", name, act, exp, cyc);
        end
    endtask

    // Model: a queue of bits still to appear on x, one per cycle; ready when at most the current bit remains.
    always @(negedge clk) begin
        bit er8, er4, eb;
        if (cyc > 0) begin
            er8 = !rst && (q8.size() <= 1);
            er4 = !rst && (q4.size() <= 1);
            chk("in_ready8", r8, er8);
            chk("in_ready4", r4, er4);
            if (q8.size() > 0) begin
                eb = q8.pop_front();
                chk("x_valid8", xv8, 1'b1);
                chk("x8", x8, eb);
                chk("busy8", b8, 1'b1);
            end else begin
                chk("x_valid8", xv8, 1'b0);
                chk("x8", x8, 1'b0);
                chk("busy8", b8, 1'b0);
            end
            if (q4.size() > 0) begin
                eb = q4.pop_front();
                chk("x_valid4", xv4, 1'b1);
                chk("x4", x4, eb);
                chk("busy4", b4, 1'b1);
            end else begin
                chk("x_valid4", xv4, 1'b0);
                chk("x4", x4, 1'b0);
                chk("busy4", b4, 1'b0);
            end
            if (rst) begin
                q8.delete();
                q4.delete();
            end else begin
                if (v8 && er8) for (int i = 0; i < 8; i++) q8.push_back(d8[7-i]);
                if (v4 && er4) for (int i = 0; i < 4; i++) q4.push_back(d4[i]);
            end
        end
    end

    task automatic send8(input logic [7:0] w);
        int n = 0;
        v8 = 1'b1;
        d8 = w;
        @(negedge clk);
        while (!r8 && n < 30) begin
            n++;
            @(negedge clk);
        end
        vectors++;
        if (!r8) begin
            miscompares++;
            $display("FAIL send8_timeout: in_ready still %b after %0d cycles, required 1", r8, n);
        end
        @(posedge clk);
        #1 v8 = 1'b0;
    endtask

    task automatic send4(input logic [3:0] w);
        int n = 0;
        v4 = 1'b1;
        d4 = w;
        @(negedge clk);
        while (!r4 && n < 30) begin
            n++;
            @(negedge clk);
        end
        vectors++;
        if (!r4) begin
            miscompares++;
            $display("FAIL send4_timeout: in_ready still %b after %0d cycles, required 1", r4, n);
        end
        @(posedge clk);
        #1 v4 = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        v8  = 1'b0;
        d8  = '0;
        v4  = 1'b0;
        d4  = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // Single word, then back-to-back pair
        send8(8'hB3);
        repeat (10) @(posedge clk);
        #1;
        send8(8'hFF);
        send8(8'h0D);
        repeat (10) @(posedge clk);
        #1;

        // Reset while the 4th bit of A5 is on x, then a fresh word
        send8(8'hA5);
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        send8(8'h3C);
        repeat (10) @(posedge clk);
        #1;

        // LSB-first, back-to-back
        send4(4'b0110);
        send4(4'b1011);
        repeat (6) @(posedge clk);
        #1;

        // Random data every cycle with random valid and occasional reset
        repeat (400) begin
            v8  = 1'($urandom_range(0, 1));
            d8  = 8'($urandom);
            v4  = 1'($urandom_range(0, 1));
            d4  = 4'($urandom);
            rst = ($urandom_range(0, 59) == 0);
            @(posedge clk);
            #1;
        end
        v8  = 1'b0;
        v4  = 1'b0;
        rst = 1'b0;
        repeat (12) @(posedge clk);
        #1;

        vectors++;
        if (q8.size() != 0 || q4.size() != 0) begin
            miscompares++;
            $display("FAIL drain: %0d/%0d bits still expected, required 0/0", q8.size(), q4.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
